// File: rtl/cla_16bit_pkg.sv
// Shared constants for the registered carry-lookahead adder.
//   WIDTH : operand / sum width (must be a multiple of GROUP)
//   GROUP : bits per lookahead group (fixed at 4)
package cla_16bit_pkg;
  localparam int WIDTH = 16;
  localparam int GROUP = 4;
endpackage

// File: rtl/cla_16bit_if.sv
// Operand / result bundle for cla_16bit.
//   master : drives a, b, cin, in_valid; observes sum, cout, out_valid
//   slave  : the adder side (inverse directions)
interface cla_16bit_if
  import cla_16bit_pkg::*;
  ;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/cla_16bit_cla4.sv
// 4-bit carry-lookahead group (module cla_4bit).
//   a, b : 4-bit operands        ci : carry into bit 0
//   s    : 4-bit sum             P  : group propagate   G : group generate
// Internal carries are flat sum-of-products, so no carry ripples inside
// the group; P and G do not depend on ci, which keeps the group-level
// lookahead two-level.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       P,
  output logic       G
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;
  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/cla_16bit.sv
// Registered carry-lookahead adder: {cout, sum} = a + b + cin, one cycle
// latency, one result per cycle. Final carry-propagate stage of the 8x8
// Dadda multiplier.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears sum, cout, out_valid)
//   bus   : cla_16bit_if.slave -- a, b, cin, in_valid in; sum, cout,
//           out_valid out (all outputs registered)
module cla_16bit
  import cla_16bit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  cla_16bit_if.slave   bus
);
  localparam int NGRP = WIDTH / GROUP;

  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      cla_4bit u_grp (
        .a  (bus.a[gi*GROUP +: GROUP]),
        .b  (bus.b[gi*GROUP +: GROUP]),
        .ci (grp_c[gi]),
        .s  (sum_d[gi*GROUP +: GROUP]),
        .P  (grp_p[gi]),
        .G  (grp_g[gi])
      );
    end
  endgenerate

  // Group-carry lookahead in expanded two-level form:
  //   C[k] = OR_j<k ( G[j] & P[j+1..k-1] )  |  ( P[0..k-1] & cin )
  // The loops only unroll into AND/OR product terms; no term depends on
  // another group carry, so there is no ripple between groups.
  always_comb begin
    logic term;
    logic acc;
    grp_c    = '0;
    grp_c[0] = bus.cin;
    for (int k = 1; k <= NGRP; k++) begin
      term = bus.cin;
      for (int j = 0; j < k; j++) term = term & grp_p[j];
      acc = term;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) term = term & grp_p[m];
        acc = acc | term;
      end
      grp_c[k] = acc;
    end
  end

  assign cout_d = grp_c[NGRP];

  // Result registers load every edge; consumers qualify with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= bus.in_valid;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_cla_16bit.sv
// Directed and streaming checks for cla_16bit.
module tb_cla_16bit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cla_16bit_if bus ();

  cla_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic v);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = v;
  endtask

  // Present one operation, wait for the capturing edge, check the result.
  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic [15:0] exp_sum, input logic exp_cout);
    @(negedge clk);
    drive(a, b, cin, 1'b1);
    @(posedge clk);
    #1;
    check_val({tag, "_sum"},  32'(bus.sum),       32'(exp_sum));
    check_val({tag, "_cout"}, 32'(bus.cout),      32'(exp_cout));
    check_val({tag, "_vld"},  32'(bus.out_valid), 32'd1);
    $display("op %s: %h + %h + %b -> %h c%b", tag, a, b, cin, bus.sum, bus.cout);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rv;
    logic [16:0] ref_val;

    n_checks = 0;
    n_fail   = 0;

    // Reset asserted from time zero with nonzero inputs.
    rst_n = 1'b0;
    drive(16'hFFFF, 16'h0001, 1'b1, 1'b1);
    #2;
    check_val("rst_sum",  32'(bus.sum),       32'd0);
    check_val("rst_cout", 32'(bus.cout),      32'd0);
    check_val("rst_vld",  32'(bus.out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hold_sum",  32'(bus.sum),       32'd0);
    check_val("rst_hold_cout", 32'(bus.cout),      32'd0);
    check_val("rst_hold_vld",  32'(bus.out_valid), 32'd0);
    $display("reset: sum=%h cout=%b vld=%b", bus.sum, bus.cout, bus.out_valid);
    @(negedge clk);
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Directed vectors.
    run_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("chain1",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("chain2",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("grp12",   16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);
    run_op("msb",     16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("grp4",    16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0);
    run_op("grp8",    16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0);
    run_op("mix",     16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1);
    // Representative final rows for 255 x 255 (= 65025 = 16'hFE01).
    run_op("mul255",  16'hAA01, 16'h5400, 1'b0, 16'hFE01, 1'b0);

    // Back-to-back random stream with in_valid gaps.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      drive(ra, rb, rc, rv);
      ref_val = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      @(posedge clk);
      #1;
      check_val("str_sum",  32'(bus.sum),       32'(ref_val[15:0]));
      check_val("str_cout", 32'(bus.cout),      32'(ref_val[16]));
      check_val("str_vld",  32'(bus.out_valid), 32'(rv));
      $display("stream %0d: %h + %h + %b v%b -> %h c%b v%b", i, ra, rb, rc,
               rv, bus.sum, bus.cout, bus.out_valid);
    end

    // Mid-stream reset: an op is pending, reset hits before its edge.
    run_op("pre_rst", 16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1);
    @(negedge clk);
    drive(16'h1111, 16'h2222, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sum",  32'(bus.sum),       32'd0);
    check_val("mid_rst_cout", 32'(bus.cout),      32'd0);
    check_val("mid_rst_vld",  32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_val("mid_hold_vld", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_vld", 32'(bus.out_valid), 32'd0);
    check_val("post_rst_sum", 32'(bus.sum),       32'h3333);
    $display("mid reset: sum=%h cout=%b vld=%b", bus.sum, bus.cout, bus.out_valid);
    run_op("post_op", 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
